// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, operation codes and flag helpers
// used by the EX-stage units (main ALU, addi_op).
package alu_pkg;

    localparam int ALU_DATA_WIDTH    = 32;
    localparam int ALU_OPCODE_LENGTH = 4;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;

    // Two's-complement add overflow from the three sign bits.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/addi_adder.sv
// Combinational wrapping adder with signed-overflow and zero flags; shared
// between addi_op and the main ALU.
module addi_adder
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  ovf,
    output logic                  zero
);

    logic [DATA_WIDTH-1:0] sum_s;

    // Carry out is deliberately dropped: the result wraps modulo 2^DATA_WIDTH.
    assign sum_s = a + b;
    assign sum   = sum_s;
    assign ovf   = add_ovf(a[DATA_WIDTH-1], b[DATA_WIDTH-1], sum_s[DATA_WIDTH-1]);
    assign zero  = (sum_s == {DATA_WIDTH{1'b0}});

endmodule

// File: rtl/addi_op.sv
// ADDI execute unit: combinational Rd for forwarding plus a stall-aware,
// valid-qualified registered copy for the EX/MEM boundary.
module addi_op
    import alu_pkg::*;
#(
    parameter int                      DATA_WIDTH    = ALU_DATA_WIDTH,
    parameter int                      OPCODE_LENGTH = ALU_OPCODE_LENGTH,
    parameter logic [OPCODE_LENGTH-1:0] ADDI_CODE    = OP_ADDI
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    Immediate,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     valid_i,
    input  logic                     stall,
    output logic [DATA_WIDTH-1:0]    Rd,
    output logic [DATA_WIDTH-1:0]    Rd_q,
    output logic                     valid_o,
    output logic                     ovf_q,
    output logic                     zero_q
);

    logic [DATA_WIDTH-1:0] sum_s;
    logic                  ovf_s;
    logic                  zero_s;
    logic                  capture_s;

    logic [DATA_WIDTH-1:0] rd_r;
    logic                  valid_r;
    logic                  ovf_r;
    logic                  zero_r;

    addi_adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .a    (SrcA),
        .b    (Immediate),
        .sum  (sum_s),
        .ovf  (ovf_s),
        .zero (zero_s)
    );

    assign capture_s = valid_i && (Operation == ADDI_CODE) && !stall;

    // EX/MEM result register: reset dominates, stall freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_r    <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else if (capture_s) begin
            rd_r    <= sum_s;
            valid_r <= 1'b1;
            ovf_r   <= ovf_s;
            zero_r  <= zero_s;
        end else if (!stall) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign Rd      = sum_s;
    assign Rd_q    = rd_r;
    assign valid_o = valid_r;
    assign ovf_q   = ovf_r;
    assign zero_q  = zero_r;

endmodule

// File: tb/tb_addi_op.sv
// Self-checking bench for addi_op: directed corner cases followed by random
// traffic, all compared against an arithmetic reference model.
module tb_addi_op;

    localparam logic [3:0] ADDI = 4'b0010;

    logic        clk;
    logic        reset;
    logic [31:0] SrcA;
    logic [31:0] Immediate;
    logic [3:0]  Operation;
    logic        valid_i;
    logic        stall;
    logic [31:0] Rd;
    logic [31:0] Rd_q;
    logic        valid_o;
    logic        ovf_q;
    logic        zero_q;

    int checks;
    int failures;

    // Reference state of the registered outputs.
    logic [31:0] m_rdq;
    logic        m_valid;
    logic        m_ovf;
    logic        m_zero;

    addi_op dut (
        .clk       (clk),
        .reset     (reset),
        .SrcA      (SrcA),
        .Immediate (Immediate),
        .Operation (Operation),
        .valid_i   (valid_i),
        .stall     (stall),
        .Rd        (Rd),
        .Rd_q      (Rd_q),
        .valid_o   (valid_o),
        .ovf_q     (ovf_q),
        .zero_q    (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle (starting just after a falling edge), check Rd
    // combinationally, advance the model at the rising edge, then check the
    // registered outputs at the following falling edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic v, input logic st, input logic rst);
        longint sa;
        longint sb;
        longint ssum;
        logic [31:0] exp_sum;
        logic        exp_ovf;
        SrcA      = a;
        Immediate = b;
        Operation = op;
        valid_i   = v;
        stall     = st;
        reset     = rst;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ssum = sa + sb;
        exp_sum = 32'((longint'(a) + longint'(b)) % 64'sd4294967296);
        exp_ovf = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
        #1;
        chk("rd_comb", Rd, exp_sum);
        @(posedge clk);
        if (rst) begin
            m_rdq = 32'd0; m_valid = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
        end else if (!st) begin
            if (v && op == ADDI) begin
                m_rdq = exp_sum; m_valid = 1'b1; m_ovf = exp_ovf; m_zero = (exp_sum == 32'd0);
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("rd_q",    Rd_q,             m_rdq);
        chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        chk("ovf_q",   {31'd0, ovf_q},   {31'd0, m_ovf});
        chk("zero_q",  {31'd0, zero_q},  {31'd0, m_zero});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks = 0; failures = 0;
        m_rdq = 32'd0; m_valid = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
        SrcA = 32'd0; Immediate = 32'd0; Operation = 4'd0;
        valid_i = 1'b0; stall = 1'b0; reset = 1'b1;
        @(negedge clk);

        // Reset state, even with a valid ADDI and stall presented.
        step(32'd1, 32'd2, ADDI, 1'b1, 1'b1, 1'b1);
        step(32'd3, 32'd4, ADDI, 1'b1, 1'b0, 1'b1);
        chk("reset_rdq", Rd_q, 32'd0);

        // Directed cases.
        step(32'h0000_000A, 32'h0000_0005, ADDI, 1'b1, 1'b0, 1'b0);
        chk("basic_rdq", Rd_q, 32'h0000_000F);
        step(32'hFFFF_FFFB, 32'h0000_0003, ADDI, 1'b1, 1'b0, 1'b0);
        chk("neg_rdq", Rd_q, 32'hFFFF_FFFE);
        step(32'h7FFF_FFFF, 32'h0000_0001, ADDI, 1'b1, 1'b0, 1'b0);
        chk("ovf_flag", {31'd0, ovf_q}, 32'd1);
        step(32'hFFFF_FFFF, 32'h0000_0001, ADDI, 1'b1, 1'b0, 1'b0);
        chk("zero_flag", {31'd0, zero_q}, 32'd1);

        // Capture then stall for three cycles with new operands.
        step(32'h0000_000A, 32'h0000_0005, ADDI, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(32'h1234_0000 + 32'(i), 32'h0000_0100, ADDI, 1'b1, 1'b1, 1'b0);
            chk("stall_hold", Rd_q, 32'h0000_000F);
        end
        step(32'h0000_0020, 32'h0000_0022, ADDI, 1'b1, 1'b0, 1'b0);
        chk("stall_release", Rd_q, 32'h0000_0042);

        // Non-ADDI operation: no capture, valid drops.
        step(32'h0000_1000, 32'h0000_0001, 4'b0110, 1'b1, 1'b0, 1'b0);
        chk("nonaddi_rdq", Rd_q, 32'h0000_0042);

        // Reset mid-stream.
        step(32'h0000_0001, 32'h0000_0001, ADDI, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0005, 32'h0000_0006, ADDI, 1'b1, 1'b0, 1'b1);
        step(32'h0000_0007, 32'h0000_0008, ADDI, 1'b1, 1'b0, 1'b0);
        chk("post_reset_capture", Rd_q, 32'h0000_000F);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) != 0) ? ADDI : 4'($urandom_range(0, 15));
            step(pick_operand(), pick_operand(), op,
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 29) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
